// File: rtl/exotiny_wb_arb.sv
// Two-master (imem/dmem) to one-slave Wishbone-classic arbiter with ack watchdog.
// Optional macro EXOTINY_ARB_RR_EN selects round-robin instead of fixed dmem>imem priority.
module exotiny_wb_arb #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            imem_stb_i,
   input  logic [AW-1:0]   imem_adr_i,
   output logic [DW-1:0]   imem_rdat_o,
   output logic            imem_ack_o,
   input  logic            dmem_stb_i,
   input  logic            dmem_we_i,
   input  logic [DW/8-1:0] dmem_be_i,
   input  logic [AW-1:0]   dmem_adr_i,
   input  logic [DW-1:0]   dmem_wdat_i,
   output logic [DW-1:0]   dmem_rdat_o,
   output logic            dmem_ack_o,
   output logic            err_o,
   output logic            mem_stb_o,
   output logic            mem_we_o,
   output logic [DW/8-1:0] mem_be_o,
   output logic [AW-1:0]   mem_adr_o,
   output logic [DW-1:0]   mem_wdat_o,
   input  logic [DW-1:0]   mem_rdat_i,
   input  logic            mem_ack_i
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          w_stb;
   logic          w_tmo;
   logic          w_pick_d;

   assign imem_rdat_o = mem_rdat_i;
   assign dmem_rdat_o = mem_rdat_i;

`ifdef EXOTINY_ARB_RR_EN
   logic r_last_d;

   // On a tie the master that did not win last time gets the bus.
   assign w_pick_d = dmem_stb_i && (!imem_stb_i || !r_last_d);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last_d <= 1'b0;
      end else if (r_state == IDLE && w_next != IDLE) begin
         r_last_d <= (w_next == GNT_D);
      end
   end
`else
   assign w_pick_d = dmem_stb_i;
`endif

   always_comb begin
      w_stb = 1'b0;
      if (r_state == GNT_I) w_stb = imem_stb_i;
      if (r_state == GNT_D) w_stb = dmem_stb_i;
   end

   // A real ack in the last watchdog cycle wins, and an abort suppresses the timeout.
   assign w_tmo = (TIMEOUT > 0) && (r_state != IDLE) && w_stb && !mem_ack_i &&
                  (r_cnt == CNT_LAST);

   always_comb begin
      w_next     = r_state;
      mem_stb_o  = 1'b0;
      mem_we_o   = 1'b0;
      mem_be_o   = '0;
      mem_adr_o  = '0;
      mem_wdat_o = '0;
      imem_ack_o = 1'b0;
      dmem_ack_o = 1'b0;
      err_o      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_d)        w_next = GNT_D;
            else if (imem_stb_i) w_next = GNT_I;
         end
         GNT_I: begin
            mem_stb_o  = imem_stb_i && !w_tmo;
            mem_be_o   = '1;
            mem_adr_o  = imem_adr_i;
            imem_ack_o = imem_stb_i && (mem_ack_i || w_tmo);
            err_o      = w_tmo;
            if (!imem_stb_i || mem_ack_i || w_tmo) w_next = IDLE;
         end
         GNT_D: begin
            mem_stb_o  = dmem_stb_i && !w_tmo;
            mem_we_o   = dmem_we_i;
            mem_be_o   = dmem_be_i;
            mem_adr_o  = dmem_adr_i;
            mem_wdat_o = dmem_wdat_i;
            dmem_ack_o = dmem_stb_i && (mem_ack_i || w_tmo);
            err_o      = w_tmo;
            if (!dmem_stb_i || mem_ack_i || w_tmo) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (rst_i) begin
         mem_stb_o  = 1'b0;
         imem_ack_o = 1'b0;
         dmem_ack_o = 1'b0;
         err_o      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state != IDLE && w_next != IDLE) ? r_cnt + CW'(1) : '0;
      end
   end

endmodule

// File: tb/tb_exotiny_wb_arb.sv
// Directed bench for exotiny_wb_arb (default fixed-priority build, TIMEOUT=4).
module tb_exotiny_wb_arb;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          imem_stb_i;
   logic [AW-1:0] imem_adr_i;
   logic [DW-1:0] imem_rdat_o;
   logic          imem_ack_o;
   logic          dmem_stb_i;
   logic          dmem_we_i;
   logic [3:0]    dmem_be_i;
   logic [AW-1:0] dmem_adr_i;
   logic [DW-1:0] dmem_wdat_i;
   logic [DW-1:0] dmem_rdat_o;
   logic          dmem_ack_o;
   logic          err_o;
   logic          mem_stb_o;
   logic          mem_we_o;
   logic [3:0]    mem_be_o;
   logic [AW-1:0] mem_adr_o;
   logic [DW-1:0] mem_wdat_o;
   logic [DW-1:0] mem_rdat_i;
   logic          mem_ack_i;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   exotiny_wb_arb #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .imem_stb_i(imem_stb_i), .imem_adr_i(imem_adr_i),
      .imem_rdat_o(imem_rdat_o), .imem_ack_o(imem_ack_o),
      .dmem_stb_i(dmem_stb_i), .dmem_we_i(dmem_we_i), .dmem_be_i(dmem_be_i),
      .dmem_adr_i(dmem_adr_i), .dmem_wdat_i(dmem_wdat_i),
      .dmem_rdat_o(dmem_rdat_o), .dmem_ack_o(dmem_ack_o),
      .err_o(err_o),
      .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_adr_o(mem_adr_o), .mem_wdat_o(mem_wdat_o),
      .mem_rdat_i(mem_rdat_i), .mem_ack_i(mem_ack_i)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic stb, input logic ia,
                          input logic da, input logic er);
      chk({tag, ".stb"},  64'(mem_stb_o),  64'(stb));
      chk({tag, ".iack"}, 64'(imem_ack_o), 64'(ia));
      chk({tag, ".dack"}, 64'(dmem_ack_o), 64'(da));
      chk({tag, ".err"},  64'(err_o),      64'(er));
   endtask

   initial begin
      rst_i = 1'b1; imem_stb_i = 1'b0; imem_adr_i = '0;
      dmem_stb_i = 1'b0; dmem_we_i = 1'b0; dmem_be_i = '0; dmem_adr_i = '0; dmem_wdat_i = '0;
      mem_rdat_i = '0; mem_ack_i = 1'b0;

      // reset: outputs quiet even with a request and a slave ack present
      tick(); tick();
      imem_stb_i = 1'b1; mem_ack_i = 1'b1;
      #2 chk_ctl("rst", 0, 0, 0, 0);
      tick();
      rst_i = 1'b0; imem_stb_i = 1'b0; mem_ack_i = 1'b0;

      // single imem read, slave acks two cycles after stb
      tick();
      imem_stb_i = 1'b1; imem_adr_i = 32'h100;
      #2 chk("t1.idle_stb", 64'(mem_stb_o), 64'd0);
      tick();
      #2 chk_ctl("t1.g1", 1, 0, 0, 0);
      chk("t1.adr", 64'(mem_adr_o), 64'h100);
      chk("t1.we", 64'(mem_we_o), 64'd0);
      chk("t1.be", 64'(mem_be_o), 64'hF);
      tick();
      #2 chk_ctl("t1.g2", 1, 0, 0, 0);
      tick();
      mem_ack_i = 1'b1; mem_rdat_i = 32'hDEADBEEF;
      #2 chk_ctl("t1.ack", 1, 1, 0, 0);
      chk("t1.irdat", 64'(imem_rdat_o), 64'hDEADBEEF);
      chk("t1.drdat", 64'(dmem_rdat_o), 64'hDEADBEEF);
      tick();
      mem_ack_i = 1'b0; imem_stb_i = 1'b0;
      #2 chk_ctl("t1.done", 0, 0, 0, 0);

      // simultaneous requests: dmem write first, one idle cycle, then imem
      tick();
      imem_stb_i = 1'b1; imem_adr_i = 32'h200;
      dmem_stb_i = 1'b1; dmem_we_i = 1'b1; dmem_adr_i = 32'h8000_0000;
      dmem_wdat_i = 32'h41; dmem_be_i = 4'h1;
      #2 chk("t2.idle_stb", 64'(mem_stb_o), 64'd0);
      tick();
      #2 chk_ctl("t2.gd", 1, 0, 0, 0);
      chk("t2.adr", 64'(mem_adr_o), 64'h8000_0000);
      chk("t2.we", 64'(mem_we_o), 64'd1);
      chk("t2.wdat", 64'(mem_wdat_o), 64'h41);
      chk("t2.be", 64'(mem_be_o), 64'h1);
      tick();
      mem_ack_i = 1'b1;
      #2 chk_ctl("t2.dack", 1, 0, 1, 0);
      tick();
      mem_ack_i = 1'b0; dmem_stb_i = 1'b0; dmem_we_i = 1'b0;
      #2 chk_ctl("t2.gap", 0, 0, 0, 0);
      tick();
      #2 chk_ctl("t2.gi", 1, 0, 0, 0);
      chk("t2.iadr", 64'(mem_adr_o), 64'h200);
      chk("t2.iwe", 64'(mem_we_o), 64'd0);
      chk("t2.iwdat", 64'(mem_wdat_o), 64'd0);
      chk("t2.ibe", 64'(mem_be_o), 64'hF);

      // slave never acks: watchdog terminates on the 4th granted cycle
      tick();
      #2 chk_ctl("t3.c2", 1, 0, 0, 0);
      tick();
      #2 chk_ctl("t3.c3", 1, 0, 0, 0);
      tick();
      #2 chk_ctl("t3.tmo", 0, 1, 0, 1);
      tick();
      imem_stb_i = 1'b0;
      #2 chk_ctl("t3.idle", 0, 0, 0, 0);

      // dmem aborts in the same cycle as a slave ack; pending imem follows
      tick();
      dmem_stb_i = 1'b1; dmem_adr_i = 32'h300; imem_stb_i = 1'b1; imem_adr_i = 32'h400;
      tick();
      #2 chk_ctl("t4.gd", 1, 0, 0, 0);
      chk("t4.adr", 64'(mem_adr_o), 64'h300);
      tick();
      dmem_stb_i = 1'b0; mem_ack_i = 1'b1;
      #2 chk_ctl("t4.abort", 0, 0, 0, 0);
      tick();
      mem_ack_i = 1'b0;
      #2 chk_ctl("t4.idle", 0, 0, 0, 0);
      tick();
      #2 chk_ctl("t4.gi", 1, 0, 0, 0);
      chk("t4.iadr", 64'(mem_adr_o), 64'h400);
      tick();
      mem_ack_i = 1'b1;
      #2 chk_ctl("t4.iack", 1, 1, 0, 0);
      tick();
      mem_ack_i = 1'b0; imem_stb_i = 1'b0;

      // reset during GNT_D, spurious ack in IDLE, then a normal imem read
      tick();
      dmem_stb_i = 1'b1; dmem_we_i = 1'b1; dmem_adr_i = 32'h500; dmem_wdat_i = 32'h55;
      dmem_be_i = 4'hF;
      tick();
      #2 chk_ctl("t5.gd", 1, 0, 0, 0);
      rst_i = 1'b1; mem_ack_i = 1'b1;
      #1 chk_ctl("t5.inrst", 0, 0, 0, 0);
      tick();
      rst_i = 1'b0; dmem_stb_i = 1'b0; dmem_we_i = 1'b0;
      #2 chk_ctl("t5.idle", 0, 0, 0, 0);
      tick();
      mem_ack_i = 1'b0; imem_stb_i = 1'b1; imem_adr_i = 32'h600;
      #2 chk_ctl("t5.req", 0, 0, 0, 0);
      tick();
      #2 chk_ctl("t5.gi", 1, 0, 0, 0);
      chk("t5.adr", 64'(mem_adr_o), 64'h600);
      tick();
      mem_ack_i = 1'b1;
      #2 chk_ctl("t5.iack", 1, 1, 0, 0);
      tick();
      mem_ack_i = 1'b0; imem_stb_i = 1'b0;
      #2 chk_ctl("t5.end", 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
